// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master: m-bit MSB-first frame, SCLK idle low, LOAD strobe period after the data.
module spi_master #(
  parameter int m   = 12,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         START,
  input  logic [m-1:0] TX_DAT,
  output logic [m-1:0] RX_DAT,
  output logic         BUSY,
  output logic         DONE,
  output logic         SCLK,
  output logic         MOSI,
  input  logic         MISO,
  output logic         LOAD
);

  localparam int            CW        = $clog2(m + 1);
  localparam logic [7:0]    HALF_LAST = 8'(DIV - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(m - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, FIN} state_t;

  state_t        state;
  logic [m-1:0]  tx_sr;
  logic [m-1:0]  rx_sr;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    div_cnt;
  logic          half_end;

  assign half_end = (div_cnt == HALF_LAST);

  // tx_sr is zero-filled, so after m shifts MOSI is already 0 for the LATCH period.
  assign MOSI = tx_sr[m-1];

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      RX_DAT  <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      SCLK    <= 1'b0;
      LOAD    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            tx_sr   <= TX_DAT;
            bit_cnt <= '0;
            div_cnt <= '0;
            SCLK    <= 1'b0;
            BUSY    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT, LATCH: begin
          if (half_end) begin
            div_cnt <= '0;
            SCLK    <= ~SCLK;
            // SCLK high at the end of a half-period marks the falling transition.
            if (SCLK) begin
              if (state == SHIFT) begin
                tx_sr   <= {tx_sr[m-2:0], 1'b0};
                rx_sr   <= {rx_sr[m-2:0], MISO};
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                  LOAD  <= 1'b1;
                  state <= LATCH;
                end
              end else begin
                LOAD   <= 1'b0;
                RX_DAT <= rx_sr;
                DONE   <= 1'b1;
                state  <= FIN;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
